// File: rtl/clk_pkg.sv
// Shared constants for the push-button front end: button indices and 50 MHz timing defaults.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package clk_pkg;

  // Bit positions of each button inside btn_level = {mid,l,r,up,down}
  localparam int unsigned BTN_MID  = 4;
  localparam int unsigned BTN_L    = 3;
  localparam int unsigned BTN_R    = 2;
  localparam int unsigned BTN_UP   = 1;
  localparam int unsigned BTN_DOWN = 0;

  // Timing defaults for a 50 MHz clock
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_PERIOD   = 5_000_000;   // 0.1 s
  localparam int unsigned DEF_LONG_CYCLES     = 100_000_000; // 2 s

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop sync, counter debounce, registered press pulse, hold counter, optional auto-repeat.
// Latency: press pulse after edge DEBOUNCE_CYCLES+1 counting from the first edge that samples the new level.
// Backpressure: none; pulses are one cycle wide and must be consumed when they appear.
module btn_debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned REPEAT_DELAY    = 10,
  parameter int unsigned REPEAT_PERIOD   = 3,
  parameter int unsigned HOLD_MAX        = 20,
  parameter int unsigned HOLD_W          = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw,
  output logic              level,
  output logic              pulse,
  output logic [HOLD_W-1:0] hold_cnt
);

  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Repeat channels cycle their hold counter between REPEAT_DELAY and the last
  // cycle of a period; other channels count up and saturate at HOLD_MAX.
  localparam int unsigned HOLD_LIM = REPEAT_EN ? (REPEAT_DELAY + REPEAT_PERIOD - 1) : HOLD_MAX;

  localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] FIRST_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);
  localparam logic [HOLD_W-1:0] RELOAD      = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_SAT    = HOLD_W'(HOLD_LIM);

  logic             s1;
  logic             s2;
  logic             stable;
  logic [DEB_W-1:0] cnt;
  logic             accept;
  logic             holding;
  logic             rep_hit;

  // Level change accepted this edge; holding means stable stays high across this edge
  always_comb begin
    accept  = 1'b0;
    holding = 1'b0;
    rep_hit = 1'b0;
    accept  = (s2 != stable) && (cnt == DEB_LAST);
    holding = stable && !accept;
    rep_hit = REPEAT_EN && holding &&
              ((hold_cnt == FIRST_LAST) || (hold_cnt == PERIOD_LAST));
  end

  // Synchroniser and debounce counter; any disagreement shorter than the window restarts it
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Hold counter: zeroed on every accepted change, runs while pressed, never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (accept) begin
      hold_cnt <= '0;
    end else if (stable) begin
      if (REPEAT_EN && (hold_cnt == PERIOD_LAST)) begin
        hold_cnt <= RELOAD;
      end else if (hold_cnt != HOLD_SAT) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // Output pulse: rising edge of the debounced level, or a repeat tick while held
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse <= 1'b0;
    end else begin
      pulse <= (accept && s2) || rep_hit;
    end
  end

  assign level = stable;

endmodule

// File: rtl/btn_conditioner.sv
// Five-button front end: per-channel debounce, press pulses, up/down auto-repeat, mid long-press.
// Latency: press_* after edge DEBOUNCE_CYCLES+1; mid_long LONG_CYCLES after press_mid.
// Backpressure: none; all outputs are free-running single-cycle pulses plus debounced levels.
module btn_conditioner
  import clk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_mid,
  input  logic       button_l,
  input  logic       button_r,
  input  logic       button_up,
  input  logic       button_down,
  output logic       press_mid,
  output logic       press_l,
  output logic       press_r,
  output logic       press_up,
  output logic       press_down,
  output logic       mid_long,
  output logic [4:0] btn_level
);

  localparam int unsigned HOLD_W =
    $clog2(max_u(LONG_CYCLES, REPEAT_DELAY + REPEAT_PERIOD - 1) + 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_mid;
  // Hold counts of the other channels are not needed at this level
  logic [HOLD_W-1:0] hold_l_unused;
  logic [HOLD_W-1:0] hold_r_unused;
  logic [HOLD_W-1:0] hold_up_unused;
  logic [HOLD_W-1:0] hold_down_unused;

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
    .HOLD_MAX(LONG_CYCLES), .HOLD_W(HOLD_W)
  ) u_mid (
    .clk(clk), .rst(rst), .raw(button_mid),
    .level(btn_level[BTN_MID]), .pulse(press_mid), .hold_cnt(hold_mid)
  );

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
    .HOLD_MAX(LONG_CYCLES), .HOLD_W(HOLD_W)
  ) u_l (
    .clk(clk), .rst(rst), .raw(button_l),
    .level(btn_level[BTN_L]), .pulse(press_l), .hold_cnt(hold_l_unused)
  );

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
    .HOLD_MAX(LONG_CYCLES), .HOLD_W(HOLD_W)
  ) u_r (
    .clk(clk), .rst(rst), .raw(button_r),
    .level(btn_level[BTN_R]), .pulse(press_r), .hold_cnt(hold_r_unused)
  );

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
    .HOLD_MAX(LONG_CYCLES), .HOLD_W(HOLD_W)
  ) u_up (
    .clk(clk), .rst(rst), .raw(button_up),
    .level(btn_level[BTN_UP]), .pulse(press_up), .hold_cnt(hold_up_unused)
  );

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
    .HOLD_MAX(LONG_CYCLES), .HOLD_W(HOLD_W)
  ) u_down (
    .clk(clk), .rst(rst), .raw(button_down),
    .level(btn_level[BTN_DOWN]), .pulse(press_down), .hold_cnt(hold_down_unused)
  );

  // Long press: fires on the edge the mid hold count reaches LONG_CYCLES; the
  // count then saturates, so this happens once per hold
  always_ff @(posedge clk) begin
    if (rst) begin
      mid_long <= 1'b0;
    end else begin
      mid_long <= btn_level[BTN_MID] && (hold_mid == LONG_LAST);
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short timing parameters.
// Table-driven vectors for single-press shapes, hand sequences for repeat, long-press and reset.
module tb_btn_conditioner;

  localparam logic [4:0] B_MID  = 5'b10000;
  localparam logic [4:0] B_L    = 5'b01000;
  localparam logic [4:0] B_R    = 5'b00100;
  localparam logic [4:0] B_UP   = 5'b00010;
  localparam logic [4:0] B_DOWN = 5'b00001;
  localparam logic [4:0] NONE   = 5'b00000;

  logic       clk = 1'b0;
  logic       rst;
  logic       button_mid, button_l, button_r, button_up, button_down;
  logic       press_mid, press_l, press_r, press_up, press_down;
  logic       mid_long;
  logic [4:0] btn_level;

  int n_checks = 0;
  int n_pass   = 0;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .LONG_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst),
    .button_mid(button_mid), .button_l(button_l), .button_r(button_r),
    .button_up(button_up), .button_down(button_down),
    .press_mid(press_mid), .press_l(press_l), .press_r(press_r),
    .press_up(press_up), .press_down(press_down),
    .mid_long(mid_long), .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] btn;     // {mid,l,r,up,down}
    int         n;       // cycles to hold these inputs, checking every cycle
    logic [4:0] press;   // expected {press_mid,press_l,press_r,press_up,press_down}
    logic       lng;
    logic [4:0] lvl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [4:0] b, input int n,
                              input logic [4:0] p, input logic l, input logic [4:0] v);
    vec_t t;
    t.rst = r; t.btn = b; t.n = n; t.press = p; t.lng = l; t.lvl = v;
    return t;
  endfunction

  // Apply inputs just after a rising edge, then look at outputs 1 time unit after the next one
  task automatic step(input logic r, input logic [4:0] b);
    rst = r;
    {button_mid, button_l, button_r, button_up, button_down} = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [4:0] ep,
                       input logic el, input logic [4:0] ev);
    logic [4:0] ap;
    ap = {press_mid, press_l, press_r, press_up, press_down};
    n_checks++;
    if (ap === ep && mid_long === el && btn_level === ev) begin
      n_pass++;
    end else begin
      $display("FAIL %s[%0d]: got press=%b long=%b level=%b, expected press=%b long=%b level=%b",
               name, idx, ap, mid_long, btn_level, ep, el, ev);
    end
  endtask

  function automatic logic rep_due(input int k);
    return (k >= 10) && ((k - 10) % 3 == 0);
  endfunction

  initial begin
    int idx;
    rst = 1'b1;
    {button_mid, button_l, button_r, button_up, button_down} = NONE;

    // Reset, then button_l single press (test 1)
    tbl.push_back(mk(1, NONE, 2,  NONE, 0, NONE));
    tbl.push_back(mk(0, B_L,  5,  NONE, 0, NONE));   // edges 0..4
    tbl.push_back(mk(0, B_L,  1,  B_L,  0, B_L));    // edge 5: press
    tbl.push_back(mk(0, B_L,  24, NONE, 0, B_L));    // held, never again
    tbl.push_back(mk(0, NONE, 5,  NONE, 0, B_L));    // release debouncing
    tbl.push_back(mk(0, NONE, 3,  NONE, 0, NONE));   // released, no pulse
    // button_r bounce then settle (test 2)
    tbl.push_back(mk(0, B_R,  2,  NONE, 0, NONE));
    tbl.push_back(mk(0, NONE, 2,  NONE, 0, NONE));
    tbl.push_back(mk(0, B_R,  2,  NONE, 0, NONE));
    tbl.push_back(mk(0, NONE, 2,  NONE, 0, NONE));
    tbl.push_back(mk(0, B_R,  5,  NONE, 0, NONE));   // final rise, edges 0..4
    tbl.push_back(mk(0, B_R,  1,  B_R,  0, B_R));    // edge 5
    tbl.push_back(mk(0, B_R,  3,  NONE, 0, B_R));
    tbl.push_back(mk(0, NONE, 5,  NONE, 0, B_R));
    tbl.push_back(mk(0, NONE, 3,  NONE, 0, NONE));
    // up and down rise together (test 5), released before any repeat
    tbl.push_back(mk(0, B_UP | B_DOWN, 5, NONE, 0, NONE));
    tbl.push_back(mk(0, B_UP | B_DOWN, 1, B_UP | B_DOWN, 0, B_UP | B_DOWN));
    tbl.push_back(mk(0, B_UP | B_DOWN, 3, NONE, 0, B_UP | B_DOWN));
    tbl.push_back(mk(0, NONE, 5, NONE, 0, B_UP | B_DOWN));
    tbl.push_back(mk(0, NONE, 3, NONE, 0, NONE));

    idx = 0;
    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        step(tbl[i].rst, tbl[i].btn);
        check("vec", idx, tbl[i].press, tbl[i].lng, tbl[i].lvl);
        idx++;
      end
    end

    // Test 3: up held 30 cycles after press, repeats at P+10, P+13, ...; release stops them
    for (int k = 0; k < 5; k++) begin step(0, B_UP); check("up_deb", k, NONE, 0, NONE); end
    step(0, B_UP); check("up_press", 0, B_UP, 0, B_UP);
    for (int k = 1; k <= 30; k++) begin
      step(0, B_UP);
      check("up_rep", k, rep_due(k) ? B_UP : NONE, 0, B_UP);
    end
    for (int k = 31; k <= 45; k++) begin
      step(0, NONE);
      check("up_rel", k, (k < 36 && rep_due(k)) ? B_UP : NONE, 0, (k < 36) ? B_UP : NONE);
    end

    // Test 4: mid held 25 cycles; mid_long once at P+20, press_mid only at P
    for (int k = 0; k < 5; k++) begin step(0, B_MID); check("mid_deb", k, NONE, 0, NONE); end
    step(0, B_MID); check("mid_press", 0, B_MID, 0, B_MID);
    for (int k = 1; k <= 25; k++) begin
      step(0, B_MID);
      check("mid_hold", k, NONE, (k == 20), B_MID);
    end
    for (int k = 0; k < 8; k++) begin
      step(0, NONE);
      check("mid_rel", k, NONE, 0, (k < 5) ? B_MID : NONE);
    end

    // Test 6: reset for one cycle while down is held mid-repeat
    for (int k = 0; k < 5; k++) begin step(0, B_DOWN); check("dn_deb", k, NONE, 0, NONE); end
    step(0, B_DOWN); check("dn_press", 0, B_DOWN, 0, B_DOWN);
    for (int k = 1; k <= 12; k++) begin
      step(0, B_DOWN);
      check("dn_rep", k, rep_due(k) ? B_DOWN : NONE, 0, B_DOWN);
    end
    step(1, B_DOWN); check("dn_rst", 0, NONE, 0, NONE);
    for (int k = 0; k < 5; k++) begin step(0, B_DOWN); check("dn_redeb", k, NONE, 0, NONE); end
    step(0, B_DOWN); check("dn_repress", 0, B_DOWN, 0, B_DOWN);
    for (int k = 0; k < 3; k++) begin step(0, B_DOWN); check("dn_held", k, NONE, 0, B_DOWN); end
    for (int k = 0; k < 7; k++) begin
      step(0, NONE);
      check("dn_rel", k, NONE, 0, (k < 5) ? B_DOWN : NONE);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
